// File: rtl/voq_scheduler_if.sv
// Handshake bundle between ingress VOQ logic, the scheduler and the crossbar.
interface voq_scheduler_if;
  logic [15:0] voq_req;
  logic [3:0]  ingress_rdy;
  logic [7:0]  sched_sel;
  logic [3:0]  sched_done;
  logic [7:0]  xbar_sel;
  logic [3:0]  xbar_valid;

  modport master (
    output voq_req, ingress_rdy,
    input  sched_sel, sched_done, xbar_sel, xbar_valid
  );

  modport slave (
    input  voq_req, ingress_rdy,
    output sched_sel, sched_done, xbar_sel, xbar_valid
  );
endinterface

// File: rtl/voq_scheduler.sv
// 4x4 VOQ crossbar scheduler: single-iteration iSLIP per slot, slot = SLOT_LEN cycles.
// Optional SCHED_STATS_EN adds grant_cnt, a running count of matched pairs.
module voq_scheduler #(
  parameter int PORT_CNT = 4,
  parameter int SLOT_LEN = 8
) (
  input logic            clk,
  input logic            rst_n,
  voq_scheduler_if.slave bus
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]    grant_cnt
`endif
);

  if (PORT_CNT != 4) begin : g_bad_port_cnt
    $error("voq_scheduler supports only PORT_CNT == 4");
  end

  localparam logic [2:0] LAST_SLOT = 3'(SLOT_LEN - 1);

  typedef enum logic [1:0] {IDLE, MATCH, XFER} state_t;
  state_t state, state_nx;

  logic [15:0] eff;
  logic [3:0]  grant [4];   // grant[j][i]: egress j grants ingress i
  logic [3:0]  acc_valid;
  logic [1:0]  acc_eg [4];
  logic [1:0]  gidx, aidx;
  logic [1:0]  gptr [4];
  logic [1:0]  aptr [4];
  logic [2:0]  slot_cnt;
  logic [7:0]  nx_sched_sel, nx_xbar_sel;
  logic [3:0]  nx_xbar_valid;
  logic [7:0]  sched_sel_q, xbar_sel_q;
  logic [3:0]  sched_done_q, xbar_valid_q;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++)
      eff[4*i +: 4] = bus.voq_req[4*i +: 4] & {4{bus.ingress_rdy[i]}};
  end

  // Round-robin search runs farthest-to-nearest so the nearest candidate is written last.
  always_comb begin
    gidx = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      grant[j] = '0;
      for (int unsigned k = 4; k > 0; k--) begin
        gidx = gptr[j] + 2'(k - 1);
        if (eff[4*gidx + j]) begin
          grant[j]       = '0;
          grant[j][gidx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    aidx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc_valid[i] = 1'b0;
      acc_eg[i]    = '0;
      for (int unsigned k = 4; k > 0; k--) begin
        aidx = aptr[i] + 2'(k - 1);
        if (grant[aidx][i]) begin
          acc_valid[i] = 1'b1;
          acc_eg[i]    = aidx;
        end
      end
    end
  end

  always_comb begin
    nx_sched_sel  = '0;
    nx_xbar_sel   = '0;
    nx_xbar_valid = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc_valid[i]) begin
        nx_sched_sel[2*i +: 2]         = acc_eg[i];
        nx_xbar_sel[2*acc_eg[i] +: 2]  = 2'(i);
        nx_xbar_valid[acc_eg[i]]       = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|eff) state_nx = MATCH;
      MATCH:   state_nx = XFER;
      XFER:    if (slot_cnt == LAST_SLOT) state_nx = (|eff) ? MATCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt     <= '0;
      sched_sel_q  <= '0;
      xbar_sel_q   <= '0;
      sched_done_q <= '0;
      xbar_valid_q <= '0;
      for (int unsigned n = 0; n < 4; n++) begin
        gptr[n] <= '0;
        aptr[n] <= '0;
      end
    end else begin
      sched_done_q <= '0;
      case (state)
        MATCH: begin
          slot_cnt     <= '0;
          sched_sel_q  <= nx_sched_sel;
          xbar_sel_q   <= nx_xbar_sel;
          xbar_valid_q <= nx_xbar_valid;
          sched_done_q <= acc_valid;
          for (int unsigned i = 0; i < 4; i++) begin
            if (acc_valid[i]) begin
              aptr[i]         <= acc_eg[i] + 2'd1;
              gptr[acc_eg[i]] <= 2'(i) + 2'd1;
            end
          end
        end
        XFER: begin
          slot_cnt <= slot_cnt + 3'd1;
          if (slot_cnt == LAST_SLOT) xbar_valid_q <= '0;
        end
        default: slot_cnt <= '0;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [2:0] match_cnt;

  always_comb begin
    match_cnt = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (acc_valid[i]) match_cnt = match_cnt + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              grant_cnt <= '0;
    else if (state == MATCH) grant_cnt <= grant_cnt + 32'(match_cnt);
  end
`endif

  assign bus.sched_sel  = sched_sel_q;
  assign bus.sched_done = sched_done_q;
  assign bus.xbar_sel   = xbar_sel_q;
  assign bus.xbar_valid = xbar_valid_q;

endmodule

// File: tb/tb_voq_scheduler.sv
// Directed self-checking bench for voq_scheduler; expected values hand-derived from iSLIP.
module tb_voq_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  voq_scheduler_if bus ();

`ifdef SCHED_STATS_EN
  logic [31:0] grant_cnt;
`endif

  voq_scheduler #(.PORT_CNT(4), .SLOT_LEN(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.sched_done == 4'h0 && n < 40);
    check({tag, "_done_seen"}, 32'(bus.sched_done != 4'h0), 32'd1);
  endtask

  task automatic check_slot(input string tag, input logic [3:0] done, input logic [7:0] ssel,
                            input logic [3:0] xv, input logic [7:0] xs);
    check({tag, "_sched_done"}, 32'(bus.sched_done), 32'(done));
    check({tag, "_sched_sel"},  32'(bus.sched_sel),  32'(ssel));
    check({tag, "_xbar_valid"}, 32'(bus.xbar_valid), 32'(xv));
    check({tag, "_xbar_sel"},   32'(bus.xbar_sel),   32'(xs));
  endtask

  task automatic check_zero(input string tag);
    check_slot(tag, 4'h0, 8'h00, 4'h0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.voq_req = '0;
    bus.ingress_rdy = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cnt;
    logic [3:0] exp_done [5];
    logic [7:0] exp_sel [5];
    exp_done = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF};
    exp_sel  = '{8'h00, 8'h01, 8'h06, 8'h1B, 8'h6C};

    bus.voq_req = '0;
    bus.ingress_rdy = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Single request 0->0, then inputs dropped mid-slot.
    bus.voq_req = 16'h0001;
    bus.ingress_rdy = 4'h1;
    wait_done("t1");
    check_slot("t1", 4'h1, 8'h00, 4'h1, 8'h00);
    bus.voq_req = '0;
    bus.ingress_rdy = '0;
    cnt = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.xbar_valid == 4'h1) cnt++;
    end
    check("t1_slot_len", cnt, 32'd8);
    check_slot("t1_idle", 4'h0, 8'h00, 4'h0, 8'h00);

    // Ingress 0 requests every egress: accept pointer walks 0,1,2.
    do_reset();
    bus.voq_req = 16'h000F;
    bus.ingress_rdy = 4'hF;
    wait_done("t2s1");
    check_slot("t2s1", 4'h1, 8'h00, 4'h1, 8'h00);
    wait_done("t2s2");
    check_slot("t2s2", 4'h1, 8'h01, 4'h2, 8'h00);
    wait_done("t2s3");
    check_slot("t2s3", 4'h1, 8'h02, 4'h4, 8'h00);

    // Full request matrix desynchronises into permutations.
    do_reset();
    bus.voq_req = 16'hFFFF;
    bus.ingress_rdy = 4'hF;
    for (int s = 0; s < 5; s++) begin
      wait_done($sformatf("t3s%0d", s + 1));
      check_slot($sformatf("t3s%0d", s + 1), exp_done[s], exp_sel[s], exp_done[s], exp_sel[s]);
    end

    // Every ingress wants egress 0: served round-robin.
    do_reset();
    bus.voq_req = 16'h1111;
    bus.ingress_rdy = 4'hF;
    for (int s = 0; s < 5; s++) begin
      wait_done($sformatf("t4s%0d", s + 1));
      check_slot($sformatf("t4s%0d", s + 1), 4'(1 << (s % 4)), 8'h00, 4'h1, 8'(s % 4));
    end
`ifdef SCHED_STATS_EN
    check("t4_grant_cnt", grant_cnt, 32'd5);
`endif

    // Asynchronous reset at slot cycle 4; pointers must restart at zero.
    do_reset();
    bus.voq_req = 16'h000F;
    bus.ingress_rdy = 4'h1;
    wait_done("t5a");
    check_slot("t5a", 4'h1, 8'h00, 4'h1, 8'h00);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("t5_async");
`ifdef SCHED_STATS_EN
    check("t5_grant_cnt", grant_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("t5b");
    check_slot("t5b", 4'h1, 8'h00, 4'h1, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voq_scheduler.md
VOQ_SCHEDULER -- requirements
Module: voq_scheduler

Interface
REQ-001 The block SHALL have parameter PORT_CNT, default 4, giving the ingress count and the egress count; it SHALL be legal only for the value 4.
REQ-002 The block SHALL have parameter SLOT_LEN, default 8, giving the cycles per transfer slot (one 8-word packet segment).
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 voq_req  input  16  VOQ non-empty flags; bit 4*i+j set means ingress i has a segment queued for egress j.
REQ-006 ingress_rdy  input  4  bit i set means ingress i can start a dequeue.
REQ-007 sched_sel  output  8  bits [2i+1:2i] give the VOQ (egress) that ingress i SHALL dequeue.
REQ-008 sched_done  output  4  bit i is a one-cycle pulse telling ingress i to start sending the segment selected by sched_sel.
REQ-009 xbar_sel  output  8  bits [2j+1:2j] give the ingress routed to egress j.
REQ-010 xbar_valid  output  4  bit j set means egress j carries a valid route this slot.

Function
REQ-011 The FSM SHALL have three states, IDLE, MATCH and XFER, and SHALL reset to IDLE.
REQ-012 An effective request SHALL be voq_req bit 4*i+j AND ingress_rdy[i].
- IDLE SHALL move to MATCH on the cycle after any effective request is seen.
- Otherwise IDLE SHALL stay in IDLE.
REQ-013 MATCH SHALL last one cycle and SHALL perform one single-iteration iSLIP round on the effective requests sampled in that cycle.
- Grant step: each egress j SHALL grant the requesting ingress nearest at or after gptr[j], round-robin modulo 4.
- Accept step: each ingress i SHALL accept the granting egress nearest at or after aptr[i], round-robin modulo 4.
REQ-014 Pointers SHALL update only for accepted pairs (i,j):
- gptr[j] SHALL become (i+1) mod 4.
- aptr[i] SHALL become (j+1) mod 4.
- Unaccepted grants SHALL leave both pointers unchanged.
REQ-015 On the cycle after MATCH (the first XFER cycle), for each matched ingress i:
- sched_done[i] SHALL be 1 for exactly that cycle.
- sched_sel[i] SHALL hold the matched egress.
REQ-016 During every XFER cycle, for each matched pair, xbar_valid[j] SHALL be 1 and xbar_sel[j] SHALL hold the matched ingress; unmatched egresses SHALL have xbar_valid 0 and xbar_sel 0.
REQ-017 XFER SHALL last exactly SLOT_LEN cycles, counted by a 3-bit slot counter from 0 to 7.
- On the last cycle it SHALL go to MATCH if any effective request is present, else to IDLE.
REQ-018 Changes to voq_req and ingress_rdy during XFER SHALL NOT alter the current match.
REQ-019 The match SHALL always be a conflict-free matching: no egress receives two ingresses and no ingress sends to two egresses.
REQ-020 sched_sel and xbar_sel SHALL hold their values until the next MATCH updates them; unmatched entries SHALL be 0.
REQ-021 A MATCH with no accepted pair SHALL still enter XFER, with all outputs zero, and count a full slot.
REQ-022 A request for an egress granted to another ingress SHALL be retried in the next MATCH, with no loss or duplication of the request.

Reset
REQ-023 While rst_n is 0, every output SHALL be 0 regardless of clk.
REQ-024 While rst_n is 0, the FSM SHALL be in IDLE, the slot counter SHALL be 0, and all gptr and aptr SHALL be 0.
REQ-025 Reset asserted mid-XFER SHALL abandon the slot immediately; the first MATCH after release SHALL behave as if from power-up.

Configuration
REQ-026 With SCHED_STATS_EN defined, the block SHALL add output grant_cnt, 32 bits, which increments by the number of matched pairs (0-4) on each MATCH cycle, wraps modulo 2^32, and resets to 0.
REQ-027 Without SCHED_STATS_EN, the grant_cnt port and its counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then voq_req=0x0001 and ingress_rdy=0x1 -> MATCH, then sched_done=0001, sched_sel=0x00, xbar_valid=0001, xbar_sel=0x00 held 8 cycles, then IDLE.
REQ-029 ingress_rdy=0xF, voq_req=0x000F (ingress 0 requests all egresses) -> egress 0 matched first slot, egress 1 second slot, egress 2 third slot (aptr[0] advancing).
REQ-030 All 16 requests set, ingress_rdy=0xF, pointers zero -> slot 1 matches only 0->0; slots 2 through 5 converge to a full permutation with xbar_valid=1111 and no duplicate xbar_sel values.
REQ-031 Requests 0x1111 (every ingress requests egress 0) held -> egress 0 served in order ingress 0, 1, 2, 3, 0 across five consecutive slots.
REQ-032 Reset pulsed at slot cycle 4 -> all outputs 0 asynchronously; after release, behaviour matches REQ-028.
REQ-033 With SCHED_STATS_EN defined, running REQ-031 for 5 slots -> grant_cnt=5.
